csh_seq: RTL and testbench

- Cache request sequencer on the MBOX side, directly downstream of MCL.
- Consumes the EBOX memory request (eboxReqIn) and performs page check and cache lookup.
- On a miss or write, runs the memory cycle, refills and retries.
- Returns cshEBOXT0, cshEBOXRetry, mboxRespIn and a page-fail strobe to MCL.

---
 rtl/csh_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_csh_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csh_seq.sv
// Cache request sequencer: page check, cache lookup, memory cycle, refill and retry for EBOX requests.
// Optional hit/miss statistics outputs are built when CSH_STATS_EN is defined.
module csh_seq #(
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned DATA_W    = 36,
  parameter int unsigned TIMEOUT   = 63,
  parameter int unsigned RETRY_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              eboxReqIn,
  input  logic              eboxWrite,
  input  logic [ADDR_W-1:0] eboxAddr,
  input  logic [DATA_W-1:0] eboxDataIn,
  input  logic              ptValid,
  input  logic              ptWritable,
  input  logic              cshHit,
  input  logic [DATA_W-1:0] cshDataIn,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memDataIn,
  output logic              cshEBOXT0,
  output logic              cshEBOXRetry,
  output logic              mboxRespIn,
  output logic              pageFail,
  output logic              memErr,
  output logic [DATA_W-1:0] eboxDataOut,
  output logic              memReq,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataOut,
  output logic              cshFill,
  output logic              busy
`ifdef CSH_STATS_EN
  ,
  output logic [15:0]       hitCount,
  output logic [15:0]       missCount
`endif
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RTY_W = $clog2(RETRY_MAX + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP,
    S_PFAIL,
    S_MEM,
    S_RETRY
  } state_t;

  state_t              state_q;
  logic                wr_q;
  logic                hit_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [RTY_W-1:0]    rty_q;

  logic                t0_q;
  logic                rstb_q;
  logic                resp_q;
  logic                pf_q;
  logic                err_q;
  logic                fill_q;
  logic                busy_q;
  logic                mreq_q;
  logic                mwr_q;
  logic [DATA_W-1:0]   dout_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mdata_q;

  logic                pt_fail;
  logic                rty_exhausted;

  assign pt_fail       = !ptValid || (wr_q && !ptWritable);
  assign rty_exhausted = (rty_q != '0) && (rty_q == RTY_W'(RETRY_MAX));

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      tmo_q   <= '0;
      rty_q   <= '0;
      t0_q    <= 1'b0;
      rstb_q  <= 1'b0;
      resp_q  <= 1'b0;
      pf_q    <= 1'b0;
      err_q   <= 1'b0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      mreq_q  <= 1'b0;
      mwr_q   <= 1'b0;
      dout_q  <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      t0_q   <= 1'b0;
      rstb_q <= 1'b0;
      resp_q <= 1'b0;
      pf_q   <= 1'b0;
      err_q  <= 1'b0;
      fill_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // MCL still holds the request during the response cycle, so skip the first IDLE cycle.
          if (eboxReqIn && !resp_q && !pf_q) begin
            maddr_q <= eboxAddr;
            mdata_q <= eboxDataIn;
            wr_q    <= eboxWrite;
            rty_q   <= '0;
            t0_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (pt_fail) begin
            state_q <= S_PFAIL;
          end else if (wr_q) begin
            hit_q   <= cshHit;
            mreq_q  <= 1'b1;
            mwr_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_MEM;
          end else if (cshHit) begin
            dout_q  <= cshDataIn;
            state_q <= S_RESP;
          end else if (rty_exhausted) begin
            err_q   <= 1'b1;
            resp_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            mreq_q  <= 1'b1;
            mwr_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= S_MEM;
          end
        end

        S_RESP: begin
          resp_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_PFAIL: begin
          pf_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_MEM: begin
          // An acknowledge in the final timeout cycle still completes normally.
          if (memAck) begin
            mreq_q <= 1'b0;
            mwr_q  <= 1'b0;
            tmo_q  <= '0;
            if (wr_q) begin
              fill_q  <= hit_q;
              resp_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              dout_q  <= memDataIn;
              fill_q  <= 1'b1;
              state_q <= S_RETRY;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            mreq_q  <= 1'b0;
            mwr_q   <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b1;
            resp_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_RETRY: begin
          rstb_q  <= 1'b1;
          rty_q   <= rty_q + RTY_W'(1);
          state_q <= S_LOOKUP;
        end

        default: begin
          busy_q  <= 1'b0;
          mreq_q  <= 1'b0;
          mwr_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cshEBOXT0    = t0_q;
  assign cshEBOXRetry = rstb_q;
  assign mboxRespIn   = resp_q;
  assign pageFail     = pf_q;
  assign memErr       = err_q;
  assign eboxDataOut  = dout_q;
  assign memReq       = mreq_q;
  assign memWrite     = mwr_q;
  assign memAddr      = maddr_q;
  assign memDataOut   = mdata_q;
  assign cshFill      = fill_q;
  assign busy         = busy_q;

`ifdef CSH_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Only first lookups of reads that pass the page check are counted; counters saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP && rty_q == '0 && !wr_q && ptValid) begin
      if (cshHit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_csh_seq.sv
// Directed self-checking bench for csh_seq: hit, miss/refill, page fail, write, timeout, retry limit, reset.
module tb_csh_seq;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 36;

  logic              clk;
  logic              reset;
  logic              eboxReqIn;
  logic              eboxWrite;
  logic [ADDR_W-1:0] eboxAddr;
  logic [DATA_W-1:0] eboxDataIn;
  logic              ptValid;
  logic              ptWritable;
  logic              cshHit;
  logic [DATA_W-1:0] cshDataIn;
  logic              memAck;
  logic [DATA_W-1:0] memDataIn;
  logic              cshEBOXT0;
  logic              cshEBOXRetry;
  logic              mboxRespIn;
  logic              pageFail;
  logic              memErr;
  logic [DATA_W-1:0] eboxDataOut;
  logic              memReq;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataOut;
  logic              cshFill;
  logic              busy;
`ifdef CSH_STATS_EN
  logic [15:0]       hitCount;
  logic [15:0]       missCount;
`endif

  int checks = 0;
  int errors = 0;

  csh_seq dut (
    .clk          (clk),
    .reset        (reset),
    .eboxReqIn    (eboxReqIn),
    .eboxWrite    (eboxWrite),
    .eboxAddr     (eboxAddr),
    .eboxDataIn   (eboxDataIn),
    .ptValid      (ptValid),
    .ptWritable   (ptWritable),
    .cshHit       (cshHit),
    .cshDataIn    (cshDataIn),
    .memAck       (memAck),
    .memDataIn    (memDataIn),
    .cshEBOXT0    (cshEBOXT0),
    .cshEBOXRetry (cshEBOXRetry),
    .mboxRespIn   (mboxRespIn),
    .pageFail     (pageFail),
    .memErr       (memErr),
    .eboxDataOut  (eboxDataOut),
    .memReq       (memReq),
    .memWrite     (memWrite),
    .memAddr      (memAddr),
    .memDataOut   (memDataOut),
    .cshFill      (cshFill),
    .busy         (busy)
`ifdef CSH_STATS_EN
    ,
    .hitCount     (hitCount),
    .missCount    (missCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    eboxReqIn  = 1'b0;
    eboxWrite  = 1'b0;
    eboxAddr   = '0;
    eboxDataIn = '0;
    ptValid    = 1'b1;
    ptWritable = 1'b1;
    cshHit     = 1'b0;
    cshDataIn  = '0;
    memAck     = 1'b0;
    memDataIn  = '0;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({cshEBOXT0, cshEBOXRetry, mboxRespIn, pageFail, memErr, memReq, memWrite, cshFill, busy} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b exp 000000000",
               {cshEBOXT0, cshEBOXRetry, mboxRespIn, pageFail, memErr, memReq, memWrite, cshFill, busy});
    end
    checks++;
    if ({eboxDataOut, memAddr, memDataOut} !== '0) begin
      errors++;
      $display("FAIL reset_data: dout %o addr %o mdata %o exp 0", eboxDataOut, memAddr, memDataOut);
    end
  endtask

  task automatic test_read_hit(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    int t0_at = 0, t0_n = 0, resp_at = 0, resp_n = 0, mreq_n = 0;
    logic [DATA_W-1:0] dout_at_resp = '0;
    eboxAddr  = addr;
    eboxWrite = 1'b0;
    ptValid   = 1'b1;
    cshHit    = 1'b1;
    cshDataIn = data;
    eboxReqIn = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (cshEBOXT0) begin t0_at = t; t0_n++; end
      if (memReq) mreq_n++;
      if (mboxRespIn) begin
        resp_at = t; resp_n++; dout_at_resp = eboxDataOut;
        eboxReqIn = 1'b0;
      end
    end
    checks++;
    if (t0_at !== 1 || t0_n !== 1) begin errors++; $display("FAIL %s_t0: at %0d n %0d exp at 1 n 1", tag, t0_at, t0_n); end
    checks++;
    if (resp_at !== 3 || resp_n !== 1) begin errors++; $display("FAIL %s_resp: at %0d n %0d exp at 3 n 1", tag, resp_at, resp_n); end
    checks++;
    if (dout_at_resp !== data) begin errors++; $display("FAIL %s_data: got %o exp %o", tag, dout_at_resp, data); end
    checks++;
    if (mreq_n !== 0) begin errors++; $display("FAIL %s_memreq: got %0d cycles exp 0", tag, mreq_n); end
    checks++;
    if (memAddr !== addr) begin errors++; $display("FAIL %s_addr: got %o exp %o", tag, memAddr, addr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b exp 0", tag, busy); end
  endtask

  task automatic test_read_miss();
    int fill_at = 0, fill_n = 0, rty_at = 0, rty_n = 0, resp_at = 0, err_n = 0, mreq_n = 0, mwr_n = 0;
    logic [DATA_W-1:0] dout_at_fill = '0, dout_at_resp = '0;
    eboxAddr  = 22'o2000;
    eboxWrite = 1'b0;
    ptValid   = 1'b1;
    cshHit    = 1'b0;
    cshDataIn = 36'o111;
    eboxReqIn = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (memReq) mreq_n++;
      if (memWrite) mwr_n++;
      if (cshFill) begin fill_at = t; fill_n++; dout_at_fill = eboxDataOut; end
      if (cshEBOXRetry) begin rty_at = t; rty_n++; end
      if (memErr) err_n++;
      if (mboxRespIn) begin resp_at = t; dout_at_resp = eboxDataOut; eboxReqIn = 1'b0; end
      if (t == 6) begin memAck = 1'b1; memDataIn = 36'o777; end
      if (t == 7) begin memAck = 1'b0; memDataIn = '0; cshHit = 1'b1; cshDataIn = 36'o777; end
    end
    checks++;
    if (mreq_n !== 5 || mwr_n !== 0) begin errors++; $display("FAIL miss_memreq: req %0d wr %0d exp 5 0", mreq_n, mwr_n); end
    checks++;
    if (fill_at !== 7 || fill_n !== 1) begin errors++; $display("FAIL miss_fill: at %0d n %0d exp 7 1", fill_at, fill_n); end
    checks++;
    if (dout_at_fill !== 36'o777) begin errors++; $display("FAIL miss_filldata: got %o exp 777", dout_at_fill); end
    checks++;
    if (rty_at !== 8 || rty_n !== 1) begin errors++; $display("FAIL miss_retry: at %0d n %0d exp 8 1", rty_at, rty_n); end
    checks++;
    if (resp_at !== 10 || err_n !== 0) begin errors++; $display("FAIL miss_resp: at %0d err %0d exp 10 0", resp_at, err_n); end
    checks++;
    if (dout_at_resp !== 36'o777) begin errors++; $display("FAIL miss_data: got %o exp 777", dout_at_resp); end
  endtask

  task automatic test_page_fail(input string tag, input logic wr);
    int pf_at = 0, pf_n = 0, resp_n = 0, mreq_n = 0, fill_n = 0;
    eboxAddr   = 22'o4000;
    eboxWrite  = wr;
    ptValid    = wr;
    ptWritable = 1'b0;
    cshHit     = 1'b1;
    eboxReqIn  = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (mboxRespIn) resp_n++;
      if (memReq) mreq_n++;
      if (cshFill) fill_n++;
      if (pageFail) begin pf_at = t; pf_n++; eboxReqIn = 1'b0; end
    end
    checks++;
    if (pf_at !== 3 || pf_n !== 1) begin errors++; $display("FAIL %s_pf: at %0d n %0d exp 3 1", tag, pf_at, pf_n); end
    checks++;
    if (resp_n !== 0 || mreq_n !== 0 || fill_n !== 0) begin
      errors++; $display("FAIL %s_side: resp %0d req %0d fill %0d exp 0 0 0", tag, resp_n, mreq_n, fill_n);
    end
    eboxWrite  = 1'b0;
    ptValid    = 1'b1;
    ptWritable = 1'b1;
  endtask

  task automatic test_write(input string tag, input logic hit);
    int fill_n = 0, resp_at = 0, exp_fill;
    logic req_after = 1'b1;
    exp_fill   = hit ? 1 : 0;
    eboxAddr   = 22'o3333;
    eboxWrite  = 1'b1;
    eboxDataIn = 36'o5;
    ptValid    = 1'b1;
    ptWritable = 1'b1;
    cshHit     = hit;
    eboxReqIn  = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 2) begin
        checks++;
        if ({memReq, memWrite} !== 2'b11 || memDataOut !== 36'o5 || memAddr !== 22'o3333) begin
          errors++;
          $display("FAIL %s_memcyc: req %b wr %b data %o addr %o exp 1 1 5 3333", tag, memReq, memWrite, memDataOut, memAddr);
        end
      end
      if (cshFill) begin
        fill_n++;
        if (!mboxRespIn) fill_n += 10;
      end
      if (mboxRespIn) begin resp_at = t; req_after = memReq; eboxReqIn = 1'b0; end
      if (t == 3) memAck = 1'b1;
      if (t == 4) memAck = 1'b0;
    end
    checks++;
    if (resp_at !== 4 || req_after !== 1'b0) begin errors++; $display("FAIL %s_resp: at %0d memReq %b exp 4 0", tag, resp_at, req_after); end
    checks++;
    if (fill_n !== exp_fill) begin errors++; $display("FAIL %s_fill: got %0d exp %0d", tag, fill_n, exp_fill); end
    eboxWrite = 1'b0;
  endtask

  task automatic test_timeout();
    int mreq_n = 0, resp_at = 0, err_at = 0;
    logic busy_after = 1'b1;
    eboxAddr  = 22'o5000;
    eboxWrite = 1'b0;
    cshHit    = 1'b0;
    eboxReqIn = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (memReq) mreq_n++;
      if (memErr) err_at = t;
      if (t == 66) busy_after = busy;
      if (mboxRespIn) begin resp_at = t; eboxReqIn = 1'b0; end
    end
    checks++;
    if (mreq_n !== 63) begin errors++; $display("FAIL tmo_memreq: got %0d cycles exp 63", mreq_n); end
    checks++;
    if (resp_at !== 65 || err_at !== 65) begin errors++; $display("FAIL tmo_err: resp %0d err %0d exp 65 65", resp_at, err_at); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b exp 0", busy_after); end
  endtask

  task automatic test_ack_in_timeout();
    int mreq_n = 0, fill_at = 0, resp_at = 0, err_n = 0;
    logic [DATA_W-1:0] dout_at_resp = '0;
    eboxAddr  = 22'o5100;
    eboxWrite = 1'b0;
    cshHit    = 1'b0;
    eboxReqIn = 1'b1;
    for (int t = 1; t <= 72; t++) begin
      tick();
      if (memReq) mreq_n++;
      if (memErr) err_n++;
      if (cshFill) fill_at = t;
      if (mboxRespIn) begin resp_at = t; dout_at_resp = eboxDataOut; eboxReqIn = 1'b0; end
      if (t == 64) begin memAck = 1'b1; memDataIn = 36'o4242; end
      if (t == 65) begin memAck = 1'b0; cshHit = 1'b1; cshDataIn = 36'o4242; end
    end
    checks++;
    if (err_n !== 0 || fill_at !== 65) begin errors++; $display("FAIL acktmo_win: err %0d fill %0d exp 0 65", err_n, fill_at); end
    checks++;
    if (resp_at !== 68 || dout_at_resp !== 36'o4242 || mreq_n !== 63) begin
      errors++; $display("FAIL acktmo_resp: at %0d data %o req %0d exp 68 4242 63", resp_at, dout_at_resp, mreq_n);
    end
  endtask

  task automatic test_retry_exhaust();
    int fill_n = 0, rty_n = 0, mreq_n = 0, resp_at = 0, err_at = 0;
    memAck    = 1'b1;
    eboxAddr  = 22'o6000;
    eboxWrite = 1'b0;
    cshHit    = 1'b0;
    eboxReqIn = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (cshFill) fill_n++;
      if (cshEBOXRetry) rty_n++;
      if (memReq) mreq_n++;
      if (memErr) err_at = t;
      if (mboxRespIn) begin resp_at = t; eboxReqIn = 1'b0; end
    end
    memAck = 1'b0;
    checks++;
    if (fill_n !== 2 || rty_n !== 2 || mreq_n !== 2) begin
      errors++; $display("FAIL rty_count: fill %0d retry %0d req %0d exp 2 2 2", fill_n, rty_n, mreq_n);
    end
    checks++;
    if (resp_at !== 8 || err_at !== 8) begin errors++; $display("FAIL rty_err: resp %0d err %0d exp 8 8", resp_at, err_at); end
  endtask

  task automatic test_back_to_back();
    int t0_first = 0, t0_second = 0, resp_n = 0;
    eboxAddr  = 22'o7000;
    eboxWrite = 1'b0;
    cshHit    = 1'b1;
    cshDataIn = 36'o12;
    eboxReqIn = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (cshEBOXT0) begin
        if (t0_first == 0) t0_first = t; else t0_second = t;
      end
      if (mboxRespIn) begin
        resp_n++;
        if (resp_n == 2) eboxReqIn = 1'b0;
      end
    end
    checks++;
    if (t0_first !== 1 || t0_second !== 5 || resp_n !== 2) begin
      errors++; $display("FAIL b2b_accept: t0 %0d %0d resp %0d exp 1 5 2", t0_first, t0_second, resp_n);
    end
  endtask

  task automatic test_reset_in_mem();
    int resp_n = 0;
    logic req_now, busy_now;
    eboxAddr  = 22'o1234;
    eboxWrite = 1'b0;
    cshHit    = 1'b0;
    eboxReqIn = 1'b1;
    for (int t = 1; t <= 4; t++) tick();
    reset     = 1'b1;
    eboxReqIn = 1'b0;
    tick();
    req_now  = memReq;
    busy_now = busy;
    reset    = 1'b0;
    if (mboxRespIn) resp_n++;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (mboxRespIn) resp_n++;
    end
    checks++;
    if (req_now !== 1'b0 || busy_now !== 1'b0) begin
      errors++; $display("FAIL rstmem_drop: memReq %b busy %b exp 0 0", req_now, busy_now);
    end
    checks++;
    if (resp_n !== 0) begin errors++; $display("FAIL rstmem_resp: got %0d exp 0", resp_n); end
    test_read_hit("post_rst", 22'o1777, 36'o76543210);
  endtask

`ifdef CSH_STATS_EN
  task automatic test_stats();
    test_reset();
    test_read_hit("stat_hit", 22'o100, 36'o1);
    test_retry_exhaust();
    checks++;
    if (hitCount !== 16'd1 || missCount !== 16'd1) begin
      errors++; $display("FAIL stats: hit %0d miss %0d exp 1 1", hitCount, missCount);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    set_idle_inputs();
    test_reset();
    test_read_hit("rd_hit", 22'o1777, 36'o123456701234);
    test_read_miss();
    test_page_fail("pf_rd", 1'b0);
    test_page_fail("pf_wr", 1'b1);
    test_write("wr_hit", 1'b1);
    test_write("wr_miss", 1'b0);
    test_timeout();
    test_ack_in_timeout();
    test_retry_exhaust();
    test_back_to_back();
    test_reset_in_mem();
`ifdef CSH_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
